// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: default receive-FIFO depth and the stored entry
// layout {err, data[7:0]} used by the FIFO and its storage array.
package uart_rx_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // One received byte plus "a receiver error happened since the previous push".
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } uart_entry_t;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between a UART receiver / consumer and uart_rx_fifo.
//   rx side     : rxData, rxDone (byte pulse), rxErr (error pulse)
//   consumer    : outData, outErr, outValid, outReady
//   status/ctrl : count, full, overrun, clearOverrun
// slave  = the FIFO itself, master = receiver + consumer environment.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int Depth = DEFAULT_DEPTH
) ();

    logic [7:0]               rxData;
    logic                     rxDone;
    logic                     rxErr;
    logic [7:0]               outData;
    logic                     outErr;
    logic                     outValid;
    logic                     outReady;
    logic [$clog2(Depth):0]   count;
    logic                     full;
    logic                     overrun;
    logic                     clearOverrun;

    modport slave (
        input  rxData, rxDone, rxErr, outReady, clearOverrun,
        output outData, outErr, outValid, count, full, overrun
    );

    modport master (
        output rxData, rxDone, rxErr, outReady, clearOverrun,
        input  outData, outErr, outValid, count, full, overrun
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// Storage array for uart_rx_fifo: Depth x 9 bits, synchronous write,
// asynchronous (combinational) read. Contents are intentionally not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int  Depth = DEFAULT_DEPTH,
    localparam int AW    = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  uart_entry_t   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output uart_entry_t   rdata_o
);

    uart_entry_t mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver. Each received byte is stored together
// with a flag telling whether a receiver error occurred since the previous
// stored byte. Overflowing bytes are dropped and flagged by a sticky overrun.
//   clk    : rising-edge clock
//   nReset : asynchronous active-low reset (storage itself is not cleared)
//   bus    : uart_rx_fifo_if.slave (rx push side, consumer pop side, status)
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int Depth = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           nReset,
    uart_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;
    // Pointers one bit wider than the address: equal -> empty, MSB-only
    // difference -> full.
    localparam logic [PW-1:0] PTR_MSB = {1'b1, {AW{1'b0}}};

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic          overrun_q, overrun_d;
    logic          errPending_q, errPending_d;

    logic          empty;
    logic          isFull;
    logic          push;
    logic          pop;
    logic          drop;
    uart_entry_t   wrEntry;
    uart_entry_t   rdEntry;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign isFull = ((wrPtr_q ^ rdPtr_q) == PTR_MSB);

    // outReady is meaningless while empty; a full FIFO can still accept a
    // byte in the cycle its head is popped.
    assign pop  = !empty && bus.outReady;
    assign push = bus.rxDone && (!isFull || pop);
    assign drop = bus.rxDone && isFull && !pop;

    // An error pulse coinciding with the byte marks that byte too.
    assign wrEntry.err  = errPending_q | bus.rxErr;
    assign wrEntry.data = bus.rxData;

    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        overrun_d    = overrun_q;
        errPending_d = errPending_q;

        if (push) wrPtr_d = wrPtr_q + PW'(1);
        if (pop)  rdPtr_d = rdPtr_q + PW'(1);

        // Set wins over clear so a drop is never lost.
        if (drop)                  overrun_d = 1'b1;
        else if (bus.clearOverrun) overrun_d = 1'b0;

        // A new error keeps the flag armed for the following byte even when
        // it arrives together with a pushed byte.
        if (bus.rxErr)  errPending_d = 1'b1;
        else if (push)  errPending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            overrun_q    <= 1'b0;
            errPending_q <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            overrun_q    <= overrun_d;
            errPending_q <= errPending_d;
        end
    end

    // The write is qualified by the reset-gated push only through the
    // pointers; a write landing during reset is harmless since the pointers
    // are cleared and the slot is treated as empty.
    uart_fifo_mem #(
        .Depth (Depth)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wrPtr_q[AW-1:0]),
        .wdata_i (wrEntry),
        .raddr_i (rdPtr_q[AW-1:0]),
        .rdata_o (rdEntry)
    );

    assign bus.outData  = rdEntry.data;
    assign bus.outErr   = rdEntry.err;
    assign bus.outValid = !empty;
    assign bus.count    = wrPtr_q - rdPtr_q;
    assign bus.full     = isFull;
    assign bus.overrun  = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic clk;
    logic nReset;
    int   checks;
    int   errors;

    uart_rx_fifo_if #(.Depth(8)) bus ();

    uart_rx_fifo #(.Depth(8)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        #3;
        checks++; if (bus.count !== 4'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.outValid); end
        checks++; if (bus.full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        step();
        step();
        nReset = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.rxData = 8'hA5;
        bus.rxDone = 1'b1;
        #1;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL single_nobypass got %b exp 0", bus.outValid); end
        step();
        bus.rxDone = 1'b0;
        checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.outValid); end
        checks++; if (bus.outData !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", bus.outData); end
        checks++; if (bus.outErr !== 1'b0)   begin errors++; $display("FAIL single_err got %b exp 0", bus.outErr); end
        checks++; if (bus.count !== 4'd1)    begin errors++; $display("FAIL single_count got %0d exp 1", bus.count); end
        bus.outReady = 1'b1;
        step();
        bus.outReady = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL single_popvalid got %b exp 0", bus.outValid); end
        checks++; if (bus.count !== 4'd0)    begin errors++; $display("FAIL single_popcount got %0d exp 0", bus.count); end
    endtask

    task automatic test_err_flag();
        logic [7:0] expD [5] = '{8'h3C, 8'h3D, 8'h77, 8'h78, 8'h79};
        logic       expE [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        // Error pulse alone, then two bytes.
        bus.rxErr = 1'b1;
        step();
        bus.rxErr  = 1'b0;
        bus.rxDone = 1'b1; bus.rxData = 8'h3C;
        step();
        bus.rxData = 8'h3D;
        step();
        // Error together with a byte: both this and the next byte flagged.
        bus.rxErr = 1'b1; bus.rxData = 8'h77;
        step();
        bus.rxErr = 1'b0; bus.rxData = 8'h78;
        step();
        bus.rxData = 8'h79;
        step();
        bus.rxDone = 1'b0;
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL err_count got %0d exp 5", bus.count); end
        bus.outReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.outData !== expD[k]) begin errors++; $display("FAIL err_data[%0d] got %h exp %h", k, bus.outData, expD[k]); end
            checks++; if (bus.outErr !== expE[k])  begin errors++; $display("FAIL err_flag[%0d] got %b exp %b", k, bus.outErr, expE[k]); end
            step();
        end
        bus.outReady = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL err_drain got %b exp 0", bus.outValid); end
    endtask

    task automatic test_full_overrun();
        logic [7:0] exp;
        for (int i = 0; i < 9; i++) begin
            bus.rxDone = 1'b1;
            bus.rxData = 8'(i);
            step();
        end
        bus.rxDone = 1'b0;
        checks++; if (bus.full !== 1'b1)     begin errors++; $display("FAIL full_flag got %b exp 1", bus.full); end
        checks++; if (bus.count !== 4'd8)    begin errors++; $display("FAIL full_count got %0d exp 8", bus.count); end
        checks++; if (bus.overrun !== 1'b1)  begin errors++; $display("FAIL full_overrun got %b exp 1", bus.overrun); end
        checks++; if (bus.outData !== 8'h00) begin errors++; $display("FAIL full_head got %h exp 00", bus.outData); end
        // Drop and clear in the same cycle: the set wins.
        bus.clearOverrun = 1'b1; bus.rxDone = 1'b1; bus.rxData = 8'h99;
        step();
        bus.rxDone = 1'b0;
        checks++; if (bus.overrun !== 1'b1)  begin errors++; $display("FAIL ovr_priority got %b exp 1", bus.overrun); end
        checks++; if (bus.count !== 4'd8)    begin errors++; $display("FAIL ovr_count got %0d exp 8", bus.count); end
        step();
        bus.clearOverrun = 1'b0;
        checks++; if (bus.overrun !== 1'b0)  begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.overrun); end
        // Push and pop together while full.
        bus.rxDone = 1'b1; bus.rxData = 8'h55; bus.outReady = 1'b1;
        step();
        bus.rxDone = 1'b0;
        checks++; if (bus.count !== 4'd8)    begin errors++; $display("FAIL pp_count got %0d exp 8", bus.count); end
        checks++; if (bus.full !== 1'b1)     begin errors++; $display("FAIL pp_full got %b exp 1", bus.full); end
        checks++; if (bus.overrun !== 1'b0)  begin errors++; $display("FAIL pp_overrun got %b exp 0", bus.overrun); end
        for (int k = 0; k < 8; k++) begin
            exp = (k < 7) ? 8'(k + 1) : 8'h55;
            checks++; if (bus.outData !== exp) begin errors++; $display("FAIL pp_pop[%0d] got %h exp %h", k, bus.outData, exp); end
            step();
        end
        bus.outReady = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL pp_drain got %b exp 0", bus.outValid); end
        checks++; if (bus.count !== 4'd0)    begin errors++; $display("FAIL pp_drcount got %0d exp 0", bus.count); end
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int  sent = 0;
        int  cyc  = 0;
        bit  doPush;
        bit  doPop;
        while ((sent < 20 || q.size() != 0) && cyc < 200) begin
            doPush       = (sent < 20) && (cyc % 3 != 2);
            bus.rxDone   = doPush;
            bus.rxData   = 8'(8'h10 + sent);
            bus.outReady = (cyc % 2 == 1) || (sent == 20);
            #1;
            checks++; if (bus.outValid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid c%0d got %b exp %b", cyc, bus.outValid, q.size() != 0); end
            checks++; if (bus.count !== 4'(q.size()))       begin errors++; $display("FAIL wrap_count c%0d got %0d exp %0d", cyc, bus.count, q.size()); end
            if (q.size() != 0) begin
                checks++; if (bus.outData !== q[0]) begin errors++; $display("FAIL wrap_data c%0d got %h exp %h", cyc, bus.outData, q[0]); end
            end
            doPop = bus.outReady && (q.size() != 0);
            if (doPush && (q.size() < 8 || doPop)) begin
                if (doPop) void'(q.pop_front());
                q.push_back(bus.rxData);
                sent++;
            end else if (doPop) begin
                void'(q.pop_front());
            end
            step();
            cyc++;
        end
        bus.rxDone   = 1'b0;
        bus.outReady = 1'b0;
        checks++; if (sent != 20 || q.size() != 0) begin errors++; $display("FAIL wrap_timeout got sent %0d left %0d exp 20/0", sent, q.size()); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL wrap_end got %b exp 0", bus.outValid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            bus.rxDone = 1'b1;
            bus.rxData = 8'(8'hA0 + i);
            step();
        end
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL mid_count got %0d exp 5", bus.count); end
        // Push and pop pending when reset hits mid-cycle.
        bus.rxData = 8'hEE; bus.outReady = 1'b1;
        #2;
        nReset = 1'b0;
        #1;
        checks++; if (bus.count !== 4'd0)    begin errors++; $display("FAIL mid_async_count got %0d exp 0", bus.count); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", bus.outValid); end
        step();
        bus.rxDone = 1'b0; bus.outReady = 1'b0;
        nReset = 1'b1;
        step();
        checks++; if (bus.count !== 4'd0)    begin errors++; $display("FAIL mid_after_count got %0d exp 0", bus.count); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %b exp 0", bus.outValid); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        nReset           = 1'b0;
        bus.rxData       = 8'h00;
        bus.rxDone       = 1'b0;
        bus.rxErr        = 1'b0;
        bus.outReady     = 1'b0;
        bus.clearOverrun = 1'b0;
        test_reset();
        test_single();
        test_err_flag();
        test_full_overrun();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter Depth, default 8, number of byte entries; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port nReset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rxData  input  8  received byte from UART receiver, valid while rxDone is high.
REQ-005 SHALL have port rxDone  input  1  single-cycle pulse, byte complete.
REQ-006 SHALL have port rxErr  input  1  single-cycle pulse, receiver framing/sync error.
REQ-007 SHALL have port outData  output  8  byte at FIFO head.
REQ-008 SHALL have port outErr  output  1  error flag of head entry.
REQ-009 SHALL have port outValid  output  1  head entry present (not empty).
REQ-010 SHALL have port outReady  input  1  consumer accepts head when outValid is high.
REQ-011 SHALL have port count  output  $clog2(Depth)+1  occupied entries, 0..Depth.
REQ-012 SHALL have port full  output  1  count == Depth.
REQ-013 SHALL have port overrun  output  1  sticky, byte dropped due to full.
REQ-014 SHALL have port clearOverrun  input  1  synchronous clear of overrun.

Function
REQ-015 SHALL push {errPending, rxData} on a clk edge where rxDone=1 and (full=0 or pop occurs that cycle).
REQ-016 SHALL pop the head entry on a clk edge where outValid=1 and outReady=1.
REQ-017 SHALL keep an errPending flag: set on rxErr=1, cleared on any push; a push in the same cycle as rxErr stores 1 and leaves errPending=1 (the error applies to the next byte).
REQ-018 SHALL define each entry's error flag as: a receiver error occurred since the previous push.
REQ-019 SHALL present outData/outErr combinationally from storage at the read pointer; these are valid only while outValid=1.
REQ-020 SHALL have a push-to-outValid latency of exactly 1 cycle; there is no same-cycle bypass when empty.
REQ-021 SHALL, when full with no pop, drop the incoming byte, leave storage and pointers unchanged, set overrun, and leave errPending unchanged.
REQ-022 SHALL, when full with simultaneous push and pop, perform both; count stays Depth.
REQ-023 SHALL, when empty, ignore outReady; a push in that cycle takes effect and no pop occurs.
REQ-024 SHALL, on simultaneous push and pop when not empty, keep count unchanged.
REQ-025 SHALL use read/write pointers of $clog2(Depth)+1 bits that wrap modulo 2*Depth; empty when pointers are equal, full when they differ only in the MSB.
REQ-026 SHALL derive count as (wrPtr - rdPtr) in pointer width.
REQ-027 SHALL let overrun set take priority over clearOverrun in the same cycle.
REQ-028 SHALL NOT alter rxData/rxDone handling when rxErr and rxDone assert together beyond REQ-017.

Reset
REQ-029 SHALL, while nReset=0, force pointers=0, count=0, outValid=0, full=0, overrun=0, errPending=0.
REQ-030 SHALL NOT reset storage contents; outData/outErr are don't-care while outValid=0.
REQ-031 SHALL discard all entries on reset mid-operation, including entries being pushed or popped in that cycle.

Structure
REQ-032 SHALL take the default depth constant and the entry type {err, data[7:0]} from the shared UART package.
REQ-033 SHALL place storage in one sub-module uart_fifo_mem (synchronous write, asynchronous read, Depth x 9 bits); pointer and flag logic stay in uart_rx_fifo.

Verification
REQ-034 SHALL cover: reset, push 0xA5 -> next cycle outValid=1, outData=0xA5, outErr=0, count=1.
REQ-035 SHALL cover: rxErr pulse, then push 0x3C, then push 0x3D -> entries are (0x3C, err=1) and (0x3D, err=0).
REQ-036 SHALL cover: Depth=8, push 0x00..0x08 with outReady=0 -> full=1, count=8, overrun=1, byte 0x08 dropped, pops return 0x00..0x07.
REQ-037 SHALL cover: full, then simultaneous push 0x55 and pop -> count=8, overrun=0, 0x55 is the last popped entry.
REQ-038 SHALL cover: 20 pushes interleaved with pops (pointer wrap past 2*Depth) -> order preserved; count never exceeds 8.
REQ-039 SHALL cover: reset asserted with count=5 -> outValid=0, count=0 asynchronously; clearOverrun with no push -> overrun=0 next cycle.
